// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared types, scan-code constants and helper functions for the PS/2 keyboard receiver.
// Maps scan-code set 2 make codes onto ASCII for letters, digits, space and enter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Odd parity: data bits together with the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] base;
        logic [7:0] shifted;
        base    = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: base = 8'h61;
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A;
            8'h45: begin base = 8'h30; shifted = 8'h29; end
            8'h16: begin base = 8'h31; shifted = 8'h21; end
            8'h1E: begin base = 8'h32; shifted = 8'h40; end
            8'h26: begin base = 8'h33; shifted = 8'h23; end
            8'h25: begin base = 8'h34; shifted = 8'h24; end
            8'h2E: begin base = 8'h35; shifted = 8'h25; end
            8'h36: begin base = 8'h36; shifted = 8'h5E; end
            8'h3D: begin base = 8'h37; shifted = 8'h26; end
            8'h3E: begin base = 8'h38; shifted = 8'h2A; end
            8'h46: begin base = 8'h39; shifted = 8'h28; end
            8'h29: begin base = 8'h20; shifted = 8'h20; end
            8'h5A: begin base = 8'h0D; shifted = 8'h0D; end
            default: begin base = 8'h00; shifted = 8'h00; end
        endcase
        // Letters share one rule for upper case instead of a second table column.
        if (base >= 8'h61 && base <= 8'h7A) begin
            shifted = base - 8'h20;
        end else begin
            shifted = shifted;
        end
        return shift ? shifted : base;
    endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_key_fifo.sv
// Synchronous character FIFO; a push while full only succeeds if a pop frees a slot in the same cycle.
module key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: conditions the line, deframes bytes, decodes set-2 make/break
// sequences to ASCII and buffers characters as the KBDR/KBSR data source.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic        Ack,
    output logic [15:0] Data_ToKBDR,
    output logic        Ready,
    output logic        Frame_Err,
    output logic        Overflow
);

    localparam int unsigned FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]     clk_sync_r;
    logic [1:0]     dat_sync_r;
    logic           filt_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           edge_r;
    logic           fall_r;
    logic [TW-1:0]  to_cnt_r;
    logic           timeout_s;

    frame_state_t   state_r, state_s;
    logic [2:0]     bit_cnt_r, bit_cnt_s;
    logic [7:0]     rx_byte_r, rx_byte_s;
    logic           par_ok_r, par_ok_s;
    logic           byte_vld_r, byte_vld_s;
    logic           frame_err_r, frame_err_s;

    logic           shift_r, shift_s;
    logic           brk_r, brk_s;
    logic           ext_r, ext_s;
    logic           is_shift_s;
    logic [7:0]     ascii_s;
    logic           push_s;

    logic [7:0]     head_s;
    logic           full_s;
    logic           empty_s;
    logic           overflow_r;

    // Two-flop synchronizers for both keyboard lines
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[0], PS2_CLK};
            dat_sync_r <= {dat_sync_r[0], PS2_DAT};
        end
    end

    // Glitch filter: the level only follows after FILTER_LEN consecutive differing samples
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= '0;
            edge_r     <= 1'b0;
            fall_r     <= 1'b0;
        end else begin
            edge_r <= 1'b0;
            fall_r <= 1'b0;
            if (clk_sync_r[1] != filt_r) begin
                if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                    filt_r     <= clk_sync_r[1];
                    filt_cnt_r <= '0;
                    edge_r     <= 1'b1;
                    fall_r     <= filt_r;
                end else begin
                    filt_cnt_r <= filt_cnt_r + FCW'(1);
                end
            end else begin
                filt_cnt_r <= '0;
            end
        end
    end

    // Inactivity counter, saturating so an idle line never wraps into a false timeout
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            to_cnt_r <= '0;
        end else if (edge_r) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TW'(TIMEOUT_CYCLES)) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_s = (state_r != ST_IDLE) && (to_cnt_r == TW'(TIMEOUT_CYCLES));

    // Frame FSM state register
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            rx_byte_r   <= 8'h00;
            par_ok_r    <= 1'b0;
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            rx_byte_r   <= rx_byte_s;
            par_ok_r    <= par_ok_s;
            byte_vld_r  <= byte_vld_s;
            frame_err_r <= frame_err_s;
        end
    end

    // Frame FSM next state: one step per filtered falling edge; timeout silently abandons
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        rx_byte_s   = rx_byte_r;
        par_ok_s    = par_ok_r;
        byte_vld_s  = 1'b0;
        frame_err_s = 1'b0;
        if (timeout_s) begin
            state_s = ST_IDLE;
        end else if (fall_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!dat_sync_r[1]) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    rx_byte_s = {dat_sync_r[1], rx_byte_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_PARITY;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_ok_s = odd_parity_ok(rx_byte_r, dat_sync_r[1]);
                    state_s  = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_sync_r[1] && par_ok_r) begin
                        byte_vld_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign is_shift_s = (rx_byte_r == SC_LSHIFT) || (rx_byte_r == SC_RSHIFT);
    assign ascii_s    = scan_to_ascii(rx_byte_r, shift_r);

    // Decoder flags
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            shift_r <= 1'b0;
            brk_r   <= 1'b0;
            ext_r   <= 1'b0;
        end else begin
            shift_r <= shift_s;
            brk_r   <= brk_s;
            ext_r   <= ext_s;
        end
    end

    // Decoder: prefixes arm flags, the next real code is consumed under them and clears them
    always_comb begin
        shift_s = shift_r;
        brk_s   = brk_r;
        ext_s   = ext_r;
        push_s  = 1'b0;
        if (!byte_vld_r) begin
            push_s = 1'b0;
        end else if (rx_byte_r == SC_EXT) begin
            ext_s = 1'b1;
        end else if (rx_byte_r == SC_BRK) begin
            brk_s = 1'b1;
        end else begin
            brk_s = 1'b0;
            ext_s = 1'b0;
            if (ext_r) begin
                push_s = 1'b0;
            end else if (brk_r) begin
                shift_s = is_shift_s ? 1'b0 : shift_r;
            end else if (is_shift_s) begin
                shift_s = 1'b1;
            end else begin
                push_s = (ascii_s != 8'h00);
            end
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clk   (Clk),
        .rst_n (Reset_N),
        .push  (push_s),
        .din   (ascii_s),
        .pop   (Ack),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sticky overflow; a coincident Ack frees the slot so that push is not a drop
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            overflow_r <= 1'b0;
        end else if (push_s && full_s && !Ack) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign Ready       = ~empty_s;
    assign Data_ToKBDR = empty_s ? 16'h0000 : {8'h00, head_s};
    assign Frame_Err   = frame_err_r;
    assign Overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench for ps2_keyboard_receiver: a keyboard model drives frames, a reference
// decoder fills the expected queue, and a monitor pops and compares whenever Ready is high.
module tb_ps2_keyboard_receiver;

    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int TO    = 1000;
    localparam int HALF  = 10;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        ack     = 1'b0;
    logic [15:0] data;
    logic        ready;
    logic        frame_err;
    logic        overflow;

    ps2_keyboard_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk         (clk),
        .Reset_N     (rst_n),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .Ack         (ack),
        .Data_ToKBDR (data),
        .Ready       (ready),
        .Frame_Err   (frame_err),
        .Overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_log[$];
    bit          mon_on = 1'b0;
    bit          ack_en = 1'b0;
    bit          man_ack = 1'b0;
    bit          m_shift = 1'b0;
    bit          m_brk = 1'b0;
    bit          m_ext = 1'b0;
    bit          exp_ovf = 1'b0;
    int          ferr_cycles = 0;
    int          exp_ferr = 0;
    event        stop_fall;

    string       letters = "abcdefghijklmnopqrstuvwxyz";
    string       digit_sh = ")!@#$%^&*(";
    logic [7:0]  letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0]  digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit sh);
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == code) return sh ? (letters[i] - 8'd32) : letters[i];
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == code) return sh ? digit_sh[i] : (8'h30 + 8'(i));
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    // Reference decoder applied to one accepted byte
    task automatic model_byte(input logic [7:0] code);
        logic [7:0] c;
        if (code == 8'hE0) m_ext = 1'b1;
        else if (code == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_ext) begin end
            else if (m_brk) begin
                if (code == 8'h12 || code == 8'h59) m_shift = 1'b0;
            end
            else if (code == 8'h12 || code == 8'h59) m_shift = 1'b1;
            else begin
                c = ref_ascii(code, m_shift);
                if (c != 8'h00) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({8'h00, c});
                    else exp_ovf = 1'b1;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit do_model);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                -> stop_fall;
                if (do_model) model_byte(code);
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1);
    endtask

    task automatic send_partial(input int nbits);
        @(negedge clk);
        for (int i = 0; i <= nbits; i++) begin
            ps2_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            $display("FAIL %s_drain: %0d chars still expected, ready %0b", name, exp_q.size(), ready);
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops the DUT when allowed and compares the head with the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (mon_on) begin
                if (frame_err) ferr_cycles++;
                if (ready && (ack_en || man_ack)) begin
                    got_log.push_back(data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_char: got %h expected none", data);
                    end else begin
                        check("fifo_head", data, exp_q.pop_front());
                    end
                    ack = 1'b1;
                    man_ack = 1'b0;
                end else if (!ready) begin
                    check("empty_data", data, 16'h0000);
                end
            end
        end
    end

    initial begin
        int r;
        #2 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", data, 16'h0000);
        check("rst_ready", {15'd0, ready}, 16'd0);
        check("rst_ferr", {15'd0, frame_err}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);

        // Single key with exact character latency
        fork
            send_frame(8'h1C, 1'b0, 1'b1);
            begin
                @(stop_fall);
                repeat (7) @(negedge clk);
                check("lat_t1_ready", {15'd0, ready}, 16'd0);
                @(negedge clk);
                check("lat_t2_ready", {15'd0, ready}, 16'd1);
                check("lat_t2_data", data, 16'h0061);
            end
        join
        @(posedge clk);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        check("pop_ready", {15'd0, ready}, 16'd0);
        check("pop_data", data, 16'h0000);
        wait_drain("single");

        // Shift sequence
        got_log.delete();
        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12); send_key(8'h1C);
        wait_drain("shift");
        check("shift_cnt", 16'(got_log.size()), 16'd2);
        check("shift_0", got_log[0], 16'h0041);
        check("shift_1", got_log[1], 16'h0061);

        // Bad parity then a good frame
        got_log.delete();
        send_frame(8'h1C, 1'b1, 1'b0);
        exp_ferr++;
        check("ferr_pulse", 16'(ferr_cycles), 16'(exp_ferr));
        send_key(8'h32);
        wait_drain("parity");
        check("parity_next", got_log[0], 16'h0062);

        // Timeout of a partial frame, then a PS2_CLK glitch shorter than the filter
        got_log.delete();
        send_partial(3);
        repeat (TO + 10) @(negedge clk);
        send_key(8'h1C);
        @(negedge clk);
        ps2_dat = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        send_key(8'h2C);
        wait_drain("timeout");
        check("timeout_char", got_log[0], 16'h0061);
        check("glitch_char", got_log[1], 16'h0074);
        check("timeout_ferr", 16'(ferr_cycles), 16'(exp_ferr));

        // Randomized key traffic
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) send_key(letter_sc[$urandom_range(0, 25)]);
            else if (r < 57) send_key(digit_sc[$urandom_range(0, 9)]);
            else if (r < 62) send_key(($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A);
            else if (r < 72) send_key(($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59);
            else if (r < 84) begin
                send_key(8'hF0);
                if ($urandom_range(0, 2) == 0) send_key(letter_sc[$urandom_range(0, 25)]);
                else send_key(($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59);
            end
            else if (r < 90) begin
                send_key(8'hE0);
                if ($urandom_range(0, 1) == 1) send_key(8'hF0);
                send_key(letter_sc[$urandom_range(0, 25)]);
            end
            else if (r < 95) send_key(($urandom_range(0, 1) == 0) ? 8'h76 : 8'h05);
            else begin
                send_frame(letter_sc[$urandom_range(0, 25)], 1'b1, 1'b0);
                exp_ferr++;
            end
        end
        wait_drain("random");
        check("random_ferr", 16'(ferr_cycles), 16'(exp_ferr));

        // Overflow: fill, coincident pop+push while full, then a dropped push
        send_key(8'hF0); send_key(8'h12);
        wait_drain("release");
        ack_en = 1'b0;
        got_log.delete();
        for (int i = 0; i < DEPTH; i++) send_key(letter_sc[i]);
        check("full_no_ovf", {15'd0, overflow}, 16'd0);
        fork
            send_frame(letter_sc[DEPTH], 1'b0, 1'b0);
            begin
                @(stop_fall);
                repeat (6) @(negedge clk);
                @(posedge clk);
                man_ack = 1'b1;
            end
        join
        model_byte(letter_sc[DEPTH]);
        check("coincident_ovf", {15'd0, overflow}, {15'd0, exp_ovf});
        send_key(letter_sc[DEPTH + 1]);
        check("drop_ovf", {15'd0, overflow}, {15'd0, exp_ovf});
        @(posedge clk);
        ack_en = 1'b1;
        wait_drain("overflow");
        check("ovf_cnt", 16'(got_log.size()), 16'(DEPTH + 1));
        for (int k = 0; k <= DEPTH; k++) check("ovf_order", got_log[k], 16'h0061 + 16'(k));
        check("ovf_sticky", {15'd0, overflow}, 16'd1);

        // Reset in the middle of a frame with characters buffered
        ack_en = 1'b0;
        send_key(8'h1C); send_key(8'h32);
        send_partial(5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_data", data, 16'h0000);
        check("mid_rst_ready", {15'd0, ready}, 16'd0);
        check("mid_rst_ferr", {15'd0, frame_err}, 16'd0);
        check("mid_rst_ovf", {15'd0, overflow}, 16'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        m_shift = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        ps2_dat = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        got_log.delete();
        ack_en = 1'b1;
        send_key(8'h1C);
        wait_drain("reset");
        check("reset_cnt", 16'(got_log.size()), 16'd1);
        check("reset_char", got_log[0], 16'h0061);
        check("final_ferr", 16'(ferr_cycles), 16'(exp_ferr));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
